rv32_issue_ctrl: RTL and testbench
==================================

RV32_ISSUE_CTRL -- requirements
Module: rv32_issue_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port f_valid  input  1  fetch offers instruction.
REQ-004 SHALL have port f_ready  output  1  controller accepts fetch word this cycle.
REQ-005 SHALL have port f_instr  input  32  rv_instr_t from fetch.
REQ-006 SHALL have port f_pc  input  32  PC of f_instr.
REQ-007 SHALL have port d_instr  output  32  held instruction, wired to decoder instr.
REQ-008 SHALL have port d_pc  output  32  PC of held instruction.
REQ-009 SHALL have port d_set_nop  output  1  wired to decoder set_nop.
REQ-010 SHALL have port d_register_wb  input  1  decoder register_wb.
REQ-011 SHALL have port d_invalid  input  1  decoder invalid.
REQ-012 SHALL have port i_valid  output  1  decoded instruction issued to execute.
REQ-013 SHALL have port i_ready  input  1  execute accepts issue.
REQ-014 SHALL have port wb_valid  input  1  writeback retiring a register write.
REQ-015 SHALL have port wb_rd  input  5  destination being retired.
REQ-016 SHALL have port br_resolved  input  1  outstanding branch/jump resolved, no redirect.
REQ-017 SHALL have port flush  input  1  redirect; discard held instruction.
REQ-018 SHALL have port illegal  output  1  one-cycle pulse on invalid instruction.

Function
REQ-019 SHALL implement FSM states EMPTY, HOLD, WAIT_BR, HALTED.
REQ-020 EMPTY: f_ready=1; f_valid captures f_instr/f_pc into hold register, next HOLD.
REQ-021 HOLD: d_set_nop=0; hazard = (rs1 used and busy[rs1]) or (rs2 used and busy[rs2]).
REQ-022 rs1 used for opcodes JALR, BRANCH, INTEGER_IMM, INTEGER_REG; rs2 used for BRANCH, INTEGER_REG.
REQ-023 HOLD: i_valid = !hazard and !d_invalid; issue fires on i_valid and i_ready.
REQ-024 On issue of non-control instruction: f_ready=1 same cycle (zero-bubble refill); capture f_valid word and stay HOLD, else go EMPTY.
REQ-025 On issue of JAL, JALR or BRANCH: go WAIT_BR with f_ready=0.
REQ-026 WAIT_BR: d_set_nop=1, i_valid=0; br_resolved -> EMPTY.
REQ-027 HOLD with d_invalid=1: illegal pulses one cycle, go HALTED; i_valid stays 0.
REQ-028 HALTED: d_set_nop=1, f_ready=0, i_valid=0; exit only by flush (-> EMPTY).
REQ-029 flush in any state: hold register invalidated, next EMPTY, no issue or capture that cycle; flush overrides all other events.
REQ-030 Scoreboard busy[31:0]: on issue with d_register_wb=1 and rd!=0, set busy[rd].
REQ-031 wb_valid clears busy[wb_rd]; clear is visible to hazard check the next cycle only.
REQ-032 Same-cycle set and clear of the same rd: set wins.
REQ-033 busy[0] SHALL read 0 always; scoreboard SHALL NOT be cleared by flush.
REQ-034 d_set_nop=1 in EMPTY, WAIT_BR, HALTED.

Reset
REQ-035 On resetn=0: state=EMPTY, busy=0, hold instr=0, d_pc=0, illegal=0, i_valid=0, f_ready=1 after release, d_set_nop=1.
REQ-036 Reset mid-operation SHALL abandon held instruction and pending branch without issuing.

Configuration
REQ-037 Macro RV32_ISSUE_PERF_EN SHALL add outputs stall_cnt (32) and issue_cnt (32).
REQ-038 With macro: stall_cnt increments each HOLD cycle with hazard=1, issue_cnt on each issue; both saturate at all ones; reset to 0.
REQ-039 Without macro: ports and counters absent; all other behaviour identical.

Structure
REQ-040 FSM state enum and used-register opcode predicates SHALL live in the shared rv32_types package.
REQ-041 Scoreboard SHALL be sub-module rv32_scoreboard (set/clear/two read ports).

Verification
REQ-042 addi x1,x0,5 then add x2,x1,x1; wb x1 at cycle 4 -> add stalls until cycle 5, issues cycle 5.
REQ-043 Back-to-back independent addi x1, addi x2, i_ready=1 -> one issue per cycle, no bubble.
REQ-044 beq issued -> f_ready=0 until br_resolved; flush instead -> EMPTY, no issue.
REQ-045 Word 0x00000000 -> illegal pulses once, HALTED, i_valid=0 until flush.
REQ-046 Issue addi x3 while wb_valid wb_rd=3 same cycle -> busy[3]=1 afterwards.
REQ-047 Assert resetn during WAIT_BR -> EMPTY, busy=0, no stray issue.

Source files
------------

// File: rtl/rv32_types.sv
// Shared RV32 front-end types: the instruction word, the issue-controller
// state enum and the opcode predicates for source-register usage.
package rv32_types;

  typedef logic [31:0] rv_instr_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HOLD,
    ST_WAIT_BR,
    ST_HALTED
  } issue_state_t;

  localparam logic [6:0] OPC_JAL         = 7'b1101111;
  localparam logic [6:0] OPC_JALR        = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH      = 7'b1100011;
  localparam logic [6:0] OPC_INTEGER_IMM = 7'b0010011;
  localparam logic [6:0] OPC_INTEGER_REG = 7'b0110011;

  // rs1 is a real source operand for these opcodes
  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_JALR) || (opc == OPC_BRANCH) ||
           (opc == OPC_INTEGER_IMM) || (opc == OPC_INTEGER_REG);
  endfunction

  // rs2 is a real source operand for these opcodes
  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_INTEGER_REG);
  endfunction

  // Control-transfer instructions that must wait for resolution
  function automatic logic is_ctrl(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/rv32_scoreboard.sv
// Register busy scoreboard: one set port, one clear port, two read ports.
// x0 never reads busy. A same-cycle set and clear of one register leaves it
// set; a clear becomes visible on the read ports the following cycle.
module rv32_scoreboard (
  input  logic       clk,
  input  logic       resetn,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       clr_en,
  input  logic [4:0] clr_rd,
  input  logic [4:0] ra_addr,
  output logic       ra_busy,
  input  logic [4:0] rb_addr,
  output logic       rb_busy
);

  logic [31:0] busy;
  logic [31:0] busy_nxt;

  // Apply clear first so a coincident set on the same register wins
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) busy <= '0;
    else         busy <= busy_nxt;
  end

  assign ra_busy = busy[ra_addr];
  assign rb_busy = busy[rb_addr];

endmodule

// File: rtl/rv32_issue_ctrl.sv
// Single-entry issue controller between fetch, decoder and execute.
// Holds one instruction, checks RAW hazards against the scoreboard, issues
// with zero-bubble refill, blocks after control transfers until resolved and
// halts on an invalid instruction until flushed.
// Optional build macro RV32_ISSUE_PERF_EN adds stall_cnt / issue_cnt outputs.
module rv32_issue_ctrl
  import rv32_types::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [31:0] f_instr,
  input  logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic        d_set_nop,
  input  logic        d_register_wb,
  input  logic        d_invalid,
  output logic        i_valid,
  input  logic        i_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        br_resolved,
  input  logic        flush,
  output logic        illegal
`ifdef RV32_ISSUE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] issue_cnt
`endif
);

  issue_state_t state;
  issue_state_t state_nxt;
  rv_instr_t    hold_instr;
  logic [31:0]  hold_pc;
  logic         capture;
  logic         issue;
  logic         hazard;
  logic         rs1_busy;
  logic         rs2_busy;
  logic [6:0]   opc;

  assign opc = hold_instr[6:0];

  rv32_scoreboard u_scoreboard (
    .clk     (clk),
    .resetn  (resetn),
    .set_en  (issue & d_register_wb),
    .set_rd  (hold_instr[11:7]),
    .clr_en  (wb_valid),
    .clr_rd  (wb_rd),
    .ra_addr (hold_instr[19:15]),
    .ra_busy (rs1_busy),
    .rb_addr (hold_instr[24:20]),
    .rb_busy (rs2_busy)
  );

  assign hazard = (uses_rs1(opc) && rs1_busy) || (uses_rs2(opc) && rs2_busy);

  // Next state and handshake outputs; flush overrides everything at the end
  always_comb begin
    state_nxt = state;
    f_ready   = 1'b0;
    i_valid   = 1'b0;
    d_set_nop = 1'b1;
    illegal   = 1'b0;
    capture   = 1'b0;
    issue     = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        f_ready = 1'b1;
        if (f_valid) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        d_set_nop = 1'b0;
        if (d_invalid) begin
          illegal   = 1'b1;
          state_nxt = ST_HALTED;
        end else begin
          i_valid = !hazard;
          if (i_valid && i_ready) begin
            issue = 1'b1;
            if (is_ctrl(opc)) begin
              state_nxt = ST_WAIT_BR;
            end else begin
              // Refill in the issue cycle so back-to-back issue has no bubble
              f_ready = 1'b1;
              if (f_valid) capture   = 1'b1;
              else         state_nxt = ST_EMPTY;
            end
          end
        end
      end
      ST_WAIT_BR: begin
        if (br_resolved) state_nxt = ST_EMPTY;
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_nxt = ST_EMPTY;
      f_ready   = 1'b0;
      i_valid   = 1'b0;
      illegal   = 1'b0;
      capture   = 1'b0;
      issue     = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_EMPTY;
    else         state <= state_nxt;
  end

  // Hold register for the instruction presented to the decoder
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (capture) begin
      hold_instr <= f_instr;
      hold_pc    <= f_pc;
    end
  end

  assign d_instr = hold_instr;
  assign d_pc    = hold_pc;

`ifdef RV32_ISSUE_PERF_EN
  // Saturating stall and issue counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (state == ST_HOLD && hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (issue && issue_cnt != '1)                      issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_issue_ctrl.sv
// Self-checking bench for rv32_issue_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_rv32_issue_ctrl;

  logic        clk;
  logic        resetn;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_set_nop;
  logic        d_register_wb;
  logic        d_invalid;
  logic        i_valid;
  logic        i_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        br_resolved;
  logic        flush;
  logic        illegal;

  int unsigned n_chk;
  int unsigned n_bad;

  // Reference model state
  bit          m_held;
  bit          m_wait;
  bit          m_halt;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit   [31:0] m_busy;
  logic [31:0] pc_ctr;

  rv32_issue_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .f_valid       (f_valid),
    .f_ready       (f_ready),
    .f_instr       (f_instr),
    .f_pc          (f_pc),
    .d_instr       (d_instr),
    .d_pc          (d_pc),
    .d_set_nop     (d_set_nop),
    .d_register_wb (d_register_wb),
    .d_invalid     (d_invalid),
    .i_valid       (i_valid),
    .i_ready       (i_ready),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .br_resolved   (br_resolved),
    .flush         (flush),
    .illegal       (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment decoder: writes-register and invalid flags by opcode
  function automatic bit dec_wb(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                      7'b0000011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic bit dec_inv(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                        7'b0000011, 7'b0010011, 7'b0110011, 7'b1100011,
                        7'b0100011});
  endfunction

  assign d_register_wb = dec_wb(d_instr);
  assign d_invalid     = dec_inv(d_instr);

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b1100011, 7'b0110011};
  endfunction

  function automatic bit ctrl_op(input logic [6:0] op);
    return op inside {7'b1101111, 7'b1100111, 7'b1100011};
  endfunction

  // Instruction builders
  function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] i_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_beq(input logic [4:0] rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'd8, 7'b1100011};
  endfunction
  function automatic logic [31:0] i_jal(input logic [4:0] rd);
    return {20'h00100, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] i_jalr(input logic [4:0] rd, rs1);
    return {12'h004, rs1, 3'b000, rd, 7'b1100111};
  endfunction
  function automatic logic [31:0] i_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs1, rs2);
    return {7'b0, rs2, rs1, 3'b010, 5'd4, 7'b0100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model
  task automatic cycle(input bit fv, input logic [31:0] fi, input bit ir,
                       input bit wbv, input logic [4:0] wbrd,
                       input bit brr, input bit fl);
    logic [6:0] op;
    bit hz, inv, fire, ctrl, empty;
    @(posedge clk);
    #1;
    f_valid = fv; f_instr = fi; f_pc = pc_ctr; i_ready = ir;
    wb_valid = wbv; wb_rd = wbrd; br_resolved = brr; flush = fl;
    #2;
    op    = m_instr[6:0];
    empty = !m_held && !m_wait && !m_halt;
    inv   = m_held && dec_inv(m_instr);
    hz    = m_held && ((reads_rs1(op) && m_busy[m_instr[19:15]]) ||
                       (reads_rs2(op) && m_busy[m_instr[24:20]]));
    ctrl  = ctrl_op(op);
    fire  = m_held && !fl && !inv && !hz && ir;
    chk("i_valid",   {31'b0, i_valid},   {31'b0, m_held && !fl && !inv && !hz});
    chk("f_ready",   {31'b0, f_ready},   {31'b0, !fl && (empty || (fire && !ctrl))});
    chk("illegal",   {31'b0, illegal},   {31'b0, inv && !fl});
    chk("d_set_nop", {31'b0, d_set_nop}, {31'b0, !m_held});
    chk("d_instr",   d_instr, m_instr);
    chk("d_pc",      d_pc,    m_pc);
    if (wbv) m_busy[wbrd] = 1'b0;
    if (fire && dec_wb(m_instr)) m_busy[m_instr[11:7]] = 1'b1;
    m_busy[0] = 1'b0;
    if (fl) begin
      m_held = 0; m_wait = 0; m_halt = 0;
    end else if (m_held) begin
      if (inv) begin
        m_held = 0; m_halt = 1;
      end else if (fire) begin
        if (ctrl) begin
          m_held = 0; m_wait = 1;
        end else if (fv) begin
          m_instr = fi; m_pc = pc_ctr;
        end else begin
          m_held = 0;
        end
      end
    end else if (empty) begin
      if (fv) begin
        m_held = 1; m_instr = fi; m_pc = pc_ctr;
      end
    end else if (m_wait && brr) begin
      m_wait = 0;
    end
    pc_ctr = pc_ctr + 32'd4;
  endtask

  // Idle cycle with optional writeback
  task automatic idle(input bit wbv, input logic [4:0] wbrd);
    cycle(1'b0, 32'h0, 1'b1, wbv, wbrd, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse checked while asserted
  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    f_valid = 0; f_instr = '0; i_ready = 0; wb_valid = 0; wb_rd = '0;
    br_resolved = 0; flush = 0;
    #2;
    m_held = 0; m_wait = 0; m_halt = 0; m_busy = '0; m_instr = '0; m_pc = '0;
    chk("rst_f_ready",   {31'b0, f_ready},   32'd1);
    chk("rst_i_valid",   {31'b0, i_valid},   32'd0);
    chk("rst_illegal",   {31'b0, illegal},   32'd0);
    chk("rst_d_set_nop", {31'b0, d_set_nop}, 32'd1);
    chk("rst_d_instr",   d_instr, 32'd0);
    chk("rst_d_pc",      d_pc,    32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic [4:0]  ra, rb, rc;
    n_chk = 0; n_bad = 0; pc_ctr = 32'h1000;
    resetn = 1'b0;
    f_valid = 0; f_instr = '0; f_pc = '0; i_ready = 0; wb_valid = 0;
    wb_rd = '0; br_resolved = 0; flush = 0;
    do_reset();

    // RAW stall: add waits for x1 retirement, issues the cycle after the clear
    cycle(1, i_addi(5'd1, 5'd0, 12'd5), 1, 0, 5'd0, 0, 0);
    cycle(1, i_add(5'd2, 5'd1, 5'd1),   1, 0, 5'd0, 0, 0);
    cycle(0, 32'h0, 1, 0, 5'd0, 0, 0);
    cycle(0, 32'h0, 1, 1, 5'd1, 0, 0);
    cycle(0, 32'h0, 1, 0, 5'd0, 0, 0);
    idle(1, 5'd2);

    // Back-to-back independent issue with no bubble
    cycle(1, i_addi(5'd1, 5'd0, 12'd1), 1, 0, 5'd0, 0, 0);
    cycle(1, i_addi(5'd2, 5'd0, 12'd2), 1, 0, 5'd0, 0, 0);
    cycle(1, i_addi(5'd5, 5'd0, 12'd3), 1, 0, 5'd0, 0, 0);
    idle(1, 5'd1);
    idle(1, 5'd2);
    idle(1, 5'd5);

    // Branch blocks fetch until resolved; then a branch cancelled by flush
    cycle(1, i_beq(5'd0, 5'd0), 1, 0, 5'd0, 0, 0);
    cycle(1, i_addi(5'd6, 5'd0, 12'd1), 1, 0, 5'd0, 0, 0);
    cycle(1, i_addi(5'd6, 5'd0, 12'd1), 1, 0, 5'd0, 0, 0);
    cycle(1, i_addi(5'd6, 5'd0, 12'd1), 1, 0, 5'd0, 1, 0);
    idle(0, 5'd0);
    cycle(1, i_beq(5'd0, 5'd0), 0, 0, 5'd0, 0, 0);
    cycle(1, i_addi(5'd6, 5'd0, 12'd1), 1, 0, 5'd0, 0, 1);
    idle(0, 5'd0);

    // Zero word is invalid: one illegal pulse, halted until flush
    cycle(1, 32'h0000_0000, 1, 0, 5'd0, 0, 0);
    cycle(1, i_addi(5'd1, 5'd0, 12'd1), 1, 0, 5'd0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, i_addi(5'd1, 5'd0, 12'd1), 1, 0, 5'd0, 1, 0);
    cycle(0, 32'h0, 1, 0, 5'd0, 0, 1);
    idle(0, 5'd0);

    // Issue of x3 coincides with retirement of x3: x3 stays busy
    cycle(1, i_addi(5'd3, 5'd0, 12'd7), 1, 0, 5'd0, 0, 0);
    cycle(1, i_add(5'd4, 5'd3, 5'd0),   1, 1, 5'd3, 0, 0);
    for (int i = 0; i < 3; i++) idle(0, 5'd0);
    idle(1, 5'd3);
    idle(0, 5'd0);
    idle(1, 5'd4);

    // Reset while waiting on a branch, with a register busy
    cycle(1, i_addi(5'd7, 5'd0, 12'd1), 1, 0, 5'd0, 0, 0);
    cycle(1, i_jalr(5'd1, 5'd0),        1, 0, 5'd0, 0, 0);
    cycle(0, 32'h0, 1, 0, 5'd0, 0, 0);
    do_reset();
    cycle(1, i_add(5'd2, 5'd7, 5'd1), 1, 0, 5'd0, 0, 0);
    idle(0, 5'd0);
    idle(0, 5'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ra = 5'($urandom_range(0, 5));
      rb = 5'($urandom_range(0, 5));
      rc = 5'($urandom_range(0, 5));
      case ($urandom_range(0, 15))
        0, 1, 2, 3: w = i_addi(ra, rb, 12'($urandom));
        4, 5, 6, 7: w = i_add(ra, rb, rc);
        8, 9:       w = i_beq(rb, rc);
        10:         w = i_jal(ra);
        11:         w = i_jalr(ra, rb);
        12:         w = i_lui(ra);
        13:         w = i_sw(rb, rc);
        14:         w = ($urandom_range(0, 3) == 0) ? 32'h0 : i_addi(ra, 5'd0, 12'd1);
        default:    w = $urandom;
      endcase
      cycle(bit'($urandom_range(0, 3) != 0), w,
            bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 6)),
            bit'($urandom_range(0, 9) < 3),
            bit'($urandom_range(0, 99) < (m_halt ? 25 : 3)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
